fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the single-cycle datapath's decode/register-file logic.
- Owns the program counter and issues word reads to a synchronous instruction memory with 1-cycle latency.
- Buffers returned instructions with their PCs in a small FIFO and presents them through a valid/ready handshake.
- Accepts redirects (branch/jump) that flush all fetched-but-unconsumed work.

Parameters:
- WORD_SIZE, 32, width of PC, addresses and instructions.
- RESET_PC, 0, byte address fetched first after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, minimum 2.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rstn  input  1  reset, synchronous, active-low.
- o_ImReq  output  1  instruction-memory read request this cycle.
- o_ImAddr  output  WORD_SIZE  word index = pc >> 2, zero-extended.
- i_ImInstruction  input  WORD_SIZE  read data; valid the cycle after an accepted o_ImReq.
- o_Valid  output  1  buffer head holds an instruction.
- o_Instruction  output  WORD_SIZE  head instruction.
- o_Pc  output  WORD_SIZE  byte PC of the head instruction.
- i_Ready  input  1  consumer accepts the head when o_Valid is high.
- i_Redirect  input  1  flush and restart fetch.
- i_RedirectPc  input  WORD_SIZE  new byte PC; bits [1:0] are forced to 0.

Behaviour:
- Reset (i_rstn=0 at a rising edge):
  - pc <= RESET_PC; FIFO count 0; inflight 0.
  - o_ImReq=0 and o_Valid=0 during and in the cycle after reset.
  - Reset overrides every other input, including a redirect in the same cycle.
- State:
  - pc: next byte address to request.
  - inflight (1 bit) with req_pc: PC of the outstanding request.
  - FIFO of {pc, instruction} pairs with count 0..FIFO_DEPTH.
- pop = o_Valid & i_Ready.
- Request rule (o_ImReq combinational):
  - o_ImReq = !i_Redirect & (count + inflight - pop < FIFO_DEPTH) & not-first-cycle-after-reset.
  - The pop credit allows one instruction per cycle in steady state with FIFO_DEPTH=2.
- Request issued:
  - o_ImAddr = pc >> 2; req_pc <= pc; pc <= pc + 4, wrapping modulo 2^WORD_SIZE.
  - inflight <= 1; otherwise inflight <= 0.
- Response:
  - If inflight=1 and i_Redirect=0, push {req_pc, i_ImInstruction} into the FIFO that cycle.
  - The request rule guarantees the FIFO never overflows.
  - A push into an empty FIFO is visible on o_Valid the next cycle (no bypass). Fetch latency from request to o_Valid is 2 cycles.
- Simultaneous push and pop: both occur; count is unchanged; order is preserved.
- Redirect (i_Redirect=1):
  - o_Valid forced 0 that cycle, so no pop occurs.
  - The arriving response is discarded; FIFO cleared; inflight <= 0.
  - pc <= {i_RedirectPc[WORD_SIZE-1:2], 2'b00}.
  - The first request to the new PC is issued the following cycle. The redirected instruction appears on o_Valid 2 cycles after that.
- Back-to-back redirects: the last one wins; no request is issued while i_Redirect is high.
- Output stability: while o_Valid=1 and i_Ready=0, o_Instruction and o_Pc hold constant.
- o_Instruction and o_Pc are don't-care when o_Valid=0. The bench checks them only under valid.
- FIFO pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset with RESET_PC=0, i_Ready=1 always, memory word n = 0x1000+n:
  - o_ImAddr sequence 0,1,2,… on consecutive cycles.
  - o_Valid first high 2 cycles after the first request, then pairs (0,0x1000), (4,0x1001), … every cycle.
- Backpressure: hold i_Ready=0 for 5 cycles mid-stream:
  - FIFO fills to 2; o_ImReq drops.
  - Head PC/instruction stay constant.
  - On release, the stream resumes with no lost or duplicated PC.
- Redirect to 0x0000_0103 while a request is outstanding and the FIFO holds 2 entries:
  - That cycle: o_Valid=0 and the response is dropped.
  - Next cycle: o_ImAddr=0x40.
  - The first subsequent valid has o_Pc=0x100.
- Redirect asserted 2 consecutive cycles (0x200 then 0x300): o_ImReq=0 both cycles, then fetch restarts at 0x300 only.
- Wrap-around: redirect to 0xFFFF_FFFC → valid PCs 0xFFFF_FFFC then 0x0000_0000.
- Reset asserted mid-stream with i_Redirect=1 in the same cycle:
  - o_Valid=0 and o_ImReq=0 for the reset cycle and the cycle after.
  - Fetch restarts at RESET_PC with no stale instruction delivered.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads to a 1-cycle synchronous
// instruction memory, and buffers {pc, instruction} pairs behind a valid/ready handshake.
module fetch_unit #(
  parameter int                    WORD_SIZE  = 32,
  parameter logic [WORD_SIZE-1:0]  RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  output logic                 o_ImReq,
  output logic [WORD_SIZE-1:0] o_ImAddr,
  input  logic [WORD_SIZE-1:0] i_ImInstruction,
  output logic                 o_Valid,
  output logic [WORD_SIZE-1:0] o_Instruction,
  output logic [WORD_SIZE-1:0] o_Pc,
  input  logic                 i_Ready,
  input  logic                 i_Redirect,
  input  logic [WORD_SIZE-1:0] i_RedirectPc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // One extra bit so count + inflight never overflows before the compare.
  localparam int OCC_W = PTR_W + 2;

  logic [WORD_SIZE-1:0] pc_q;
  logic [WORD_SIZE-1:0] req_pc_q;
  logic                 inflight_q;
  logic                 first_q;

  logic [WORD_SIZE-1:0] fifo_pc    [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] fifo_instr [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [CNT_W-1:0]     count_q;

  logic                 pop;
  logic                 push;
  logic [OCC_W-1:0]     occupancy;
  logic                 unused_redirect_lsbs;

  // Low address bits of a redirect target are ignored; words are always aligned.
  assign unused_redirect_lsbs = ^i_RedirectPc[1:0];

  // A redirect or reset hides the head so nothing is consumed while the buffer flushes.
  assign o_Valid       = i_rstn & ~i_Redirect & (count_q != '0);
  assign o_Instruction = fifo_instr[rd_ptr_q];
  assign o_Pc          = fifo_pc[rd_ptr_q];

  assign pop  = o_Valid & i_Ready;
  assign push = i_rstn & inflight_q & ~i_Redirect;

  // Entries owned after this cycle; crediting the pop keeps one fetch per cycle at depth 2.
  assign occupancy = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);

  assign o_ImReq  = i_rstn & ~first_q & ~i_Redirect & (occupancy < OCC_W'(FIFO_DEPTH));
  assign o_ImAddr = {2'b00, pc_q[WORD_SIZE-1:2]};

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let later statements see updated state.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      pc_q       <= {RESET_PC[WORD_SIZE-1:2], 2'b00};
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      first_q    <= 1'b0;
      inflight_q <= o_ImReq;
      if (i_Redirect) begin
        pc_q <= {i_RedirectPc[WORD_SIZE-1:2], 2'b00};
      end else if (o_ImReq) begin
        req_pc_q <= pc_q;
        pc_q     <= pc_q + WORD_SIZE'(4);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_Redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: the buffer storage has no reset; count_q alone decides which entries are
  // meaningful, and leaving the array unreset lets it map onto plain flops or LUT RAM.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_pc[wr_ptr_q]    <= req_pc_q;
      fifo_instr[wr_ptr_q] <= i_ImInstruction;
    end
  end

endmodule
